// File: rtl/regfile_2r1w.sv
// regfile_2r1w: operand register file, one write port and two independent
// registered read ports (A, B). Entry 0 can be hardwired to zero and a
// same-cycle write can be forwarded to a read at the same address.
//
// Ports:
//   clk                  rising-edge clock
//   reset                synchronous, active-high; clears contents and outputs
//   wr_en/wr_addr/wr_data          write request
//   rd_en_a/rd_addr_a              read request, port A
//   rd_data_a/rd_valid_a           registered result, port A (one cycle later)
//   rd_en_b/rd_addr_b              read request, port B
//   rd_data_b/rd_valid_b           registered result, port B (one cycle later)
module regfile_2r1w #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en_a,
  input  logic [ADDR_W-1:0] rd_addr_a,
  output logic [WIDTH-1:0]  rd_data_a,
  output logic              rd_valid_a,
  input  logic              rd_en_b,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [WIDTH-1:0]  rd_data_b,
  output logic              rd_valid_b
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  logic [WIDTH-1:0] rd_data_a_q, rd_data_a_d;
  logic [WIDTH-1:0] rd_data_b_q, rd_data_b_d;
  logic             rd_valid_a_q, rd_valid_a_d;
  logic             rd_valid_b_q, rd_valid_b_d;

  logic wr_zero;
  logic rd_zero_a, rd_zero_b;
  logic hit_a, hit_b;

  // Address-0 qualifiers only matter when entry 0 is hardwired
  assign wr_zero   = (ZERO_REG != 0) && (wr_addr == '0);
  assign rd_zero_a = (ZERO_REG != 0) && (rd_addr_a == '0);
  assign rd_zero_b = (ZERO_REG != 0) && (rd_addr_b == '0);

  // Same-cycle write hitting each read address
  assign hit_a = (BYPASS != 0) && wr_en && (wr_addr == rd_addr_a);
  assign hit_b = (BYPASS != 0) && wr_en && (wr_addr == rd_addr_b);

  // Write port next state; writes to a hardwired zero entry are dropped
  always_comb begin
    mem_d = mem_q;
    if (wr_en && !wr_zero) begin
      mem_d[wr_addr] = wr_data;
    end
  end

  // Read port A next state; data holds when no request is made
  always_comb begin
    rd_data_a_d  = rd_data_a_q;
    rd_valid_a_d = rd_en_a;
    if (rd_en_a) begin
      if (rd_zero_a) begin
        rd_data_a_d = '0;
      end else if (hit_a) begin
        rd_data_a_d = wr_data;
      end else begin
        rd_data_a_d = mem_q[rd_addr_a];
      end
    end
  end

  // Read port B next state; data holds when no request is made
  always_comb begin
    rd_data_b_d  = rd_data_b_q;
    rd_valid_b_d = rd_en_b;
    if (rd_en_b) begin
      if (rd_zero_b) begin
        rd_data_b_d = '0;
      end else if (hit_b) begin
        rd_data_b_d = wr_data;
      end else begin
        rd_data_b_d = mem_q[rd_addr_b];
      end
    end
  end

  // State registers; reset wins over any same-cycle request
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q        <= '{default: '0};
      rd_data_a_q  <= '0;
      rd_data_b_q  <= '0;
      rd_valid_a_q <= 1'b0;
      rd_valid_b_q <= 1'b0;
    end else begin
      mem_q        <= mem_d;
      rd_data_a_q  <= rd_data_a_d;
      rd_data_b_q  <= rd_data_b_d;
      rd_valid_a_q <= rd_valid_a_d;
      rd_valid_b_q <= rd_valid_b_d;
    end
  end

  assign rd_data_a  = rd_data_a_q;
  assign rd_valid_a = rd_valid_a_q;
  assign rd_data_b  = rd_data_b_q;
  assign rd_valid_b = rd_valid_b_q;

endmodule
